mem_port_arbiter: RTL and testbench

- Shares the single-port unified memory between the IF stage (instruction fetch) and the MEM stage (data load/store) of the pipelined CPU.
- Sequences fixed-latency memory accesses and grants the memory to one requester at a time.
- Generates the pipeline stall controls pc_write, ifid_write and pipe_stall.
- Sits between the dataPath stage logic and the memory; hazard stalls from the hazard logic are ANDed externally.

---
 rtl/cpu_mem_pkg.sv | 18 +
 rtl/mem_wait_counter.sv | 31 +++
 rtl/mem_port_arbiter.sv | 128 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_mem_pkg.sv
// Shared types for the unified-memory port arbiter: FSM states, grant
// identifiers and the default memory access latency.
package cpu_mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY_I,
    BUSY_D
  } arb_state_t;

  typedef enum logic {
    GNT_I,
    GNT_D
  } grant_t;

  localparam int DEFAULT_MEM_LAT = 2;

endpackage

// File: rtl/mem_wait_counter.sv
// Access-cycle counter: cleared when a new access is decided, counts up
// while an access is in flight, and flags the final (completion) cycle.
module mem_wait_counter
  import cpu_mem_pkg::*;
#(
  parameter int MEM_LAT = DEFAULT_MEM_LAT,
  parameter int CNT_W   = $clog2(MEM_LAT) + 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic done
);

  logic [CNT_W-1:0] cnt;

  // Clear has priority so a back-to-back access always starts at zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign done = (cnt == CNT_W'(MEM_LAT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-port unified memory between instruction fetch and
// data load/store, sequences fixed-latency accesses and drives the
// pipeline stall controls.
module mem_port_arbiter
  import cpu_mem_pkg::*;
#(
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 16,
  parameter int MEM_LAT = DEFAULT_MEM_LAT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              flush,
  input  logic              dm_read,
  input  logic              dm_write,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_ready,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              pipe_stall
);

  arb_state_t state;
  grant_t     last_grant;

  logic done;
  logic d_pend;
  logic i_pend;
  logic grant_d;
  logic grant_i;
  logic fetch_done;
  logic data_done;
  logic decide;
  logic cnt_en;

  mem_wait_counter #(
    .MEM_LAT(MEM_LAT)
  ) u_wait_counter (
    .clk   (clk),
    .rst   (rst),
    .clear (decide),
    .enable(cnt_en),
    .done  (done)
  );

  // Grant decision: a requester is masked while it is completing or while
  // its ready pulses; data wins unless it won last time.
  always_comb begin
    d_pend     = (dm_read | dm_write) & ~dm_ready & (state != BUSY_D);
    i_pend     = if_req & ~if_ready & ~flush & (state != BUSY_I);
    grant_d    = d_pend & (~i_pend | (last_grant == GNT_I));
    grant_i    = i_pend & ~grant_d;
    fetch_done = (state == BUSY_I) & done & ~flush;
    data_done  = (state == BUSY_D) & done;
    decide     = (state == IDLE) | fetch_done | data_done | ((state == BUSY_I) & flush);
    cnt_en     = ~decide;
  end

  // Access sequencer: captures read data on completion, pulses ready for
  // one cycle and launches the next access without an idle cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      last_grant <= GNT_I;
      if_rdata   <= '0;
      dm_rdata   <= '0;
      if_ready   <= 1'b0;
      dm_ready   <= 1'b0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      if_ready <= 1'b0;
      dm_ready <= 1'b0;

      if (fetch_done) begin
        if_rdata   <= mem_rdata;
        if_ready   <= 1'b1;
        last_grant <= GNT_I;
      end

      if (data_done) begin
        if (!mem_we) begin
          dm_rdata <= mem_rdata;
        end
        dm_ready   <= 1'b1;
        last_grant <= GNT_D;
      end

      if (decide) begin
        if (grant_d) begin
          state     <= BUSY_D;
          mem_en    <= 1'b1;
          mem_we    <= dm_write;
          mem_addr  <= dm_addr;
          mem_wdata <= dm_wdata;
        end else if (grant_i) begin
          state     <= BUSY_I;
          mem_en    <= 1'b1;
          mem_we    <= 1'b0;
          mem_addr  <= if_addr;
          mem_wdata <= '0;
        end else begin
          state  <= IDLE;
          mem_en <= 1'b0;
          mem_we <= 1'b0;
        end
      end
    end
  end

  assign pipe_stall = (dm_read | dm_write) & ~dm_ready;
  assign pc_write   = ~pipe_stall & (~if_req | if_ready);
  assign ifid_write = pc_write;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: a behavioural memory, a
// requester model and expected-data queues compared on every ready pulse.
module tb_mem_port_arbiter;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 16;
  localparam int LAT    = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              if_req = 1'b0;
  logic [ADDR_W-1:0] if_addr = '0;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ready;
  logic              flush = 1'b0;
  logic              dm_read = 1'b0;
  logic              dm_write = 1'b0;
  logic [ADDR_W-1:0] dm_addr = '0;
  logic [DATA_W-1:0] dm_wdata = '0;
  logic [DATA_W-1:0] dm_rdata;
  logic              dm_ready;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              pc_write;
  logic              ifid_write;
  logic              pipe_stall;

  mem_port_arbiter #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .MEM_LAT(LAT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_rdata  (if_rdata),
    .if_ready  (if_ready),
    .flush     (flush),
    .dm_read   (dm_read),
    .dm_write  (dm_write),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_rdata  (dm_rdata),
    .dm_ready  (dm_ready),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .pc_write  (pc_write),
    .ifid_write(ifid_write),
    .pipe_stall(pipe_stall)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Memory model: fixed pattern overlaid by whatever has been stored.
  bit              wr_valid [0:4095];
  logic [DATA_W-1:0] wr_data [0:4095];
  int              acc_cnt;

  function automatic logic [DATA_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
    if (wr_valid[a]) return wr_data[a];
    if (a == 12'h010) return 16'hA5C3;
    return {a[3:0], a} ^ 16'h5A5A;
  endfunction

  // Read data is only valid in the final cycle of an access.
  assign mem_rdata = (mem_en && acc_cnt == LAT - 1) ? mem_word(mem_addr) : 16'hBAD0;

  // Track the access cycle and commit stores on their final cycle.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_cnt <= 0;
    end else if (mem_en) begin
      if (mem_we && acc_cnt == LAT - 1) begin
        wr_valid[mem_addr] <= 1'b1;
        wr_data[mem_addr]  <= mem_wdata;
      end
      acc_cnt <= (acc_cnt == LAT - 1) ? 0 : acc_cnt + 1;
    end else begin
      acc_cnt <= 0;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard queues of expected read data per requester.
  logic [DATA_W-1:0] if_exp[$];
  logic [DATA_W-1:0] dm_exp[$];
  logic [DATA_W-1:0] if_hold = '0;
  logic [DATA_W-1:0] dm_hold = '0;
  logic [DATA_W-1:0] mon_exp;

  // Compare returned data against the scoreboard on every ready pulse.
  always @(negedge clk) begin
    if (rst) begin
      if (if_ready) begin
        if (if_exp.size() == 0) checkOutput("if_unexpected_ready", 32'd1, 32'd0);
        else begin
          mon_exp = if_exp.pop_front();
          checkOutput("if_rdata", {16'd0, if_rdata}, {16'd0, mon_exp});
        end
      end
      if (dm_ready) begin
        if (dm_exp.size() == 0) checkOutput("dm_unexpected_ready", 32'd1, 32'd0);
        else begin
          mon_exp = dm_exp.pop_front();
          checkOutput("dm_rdata", {16'd0, dm_rdata}, {16'd0, mon_exp});
        end
      end
    end
  end

  // Per-window statistics gathered by runCycles.
  int mem_en_cnt, we_cnt, we_bad, stall_cnt, pc_bad;
  int dm_rdy_cnt, if_rdy_cnt, dm_rdy_at, if_rdy_at;
  int last_d, last_i, max_gap, ord_n;
  logic [31:0] ord_bits;
  bit cont_dm = 1'b0;
  bit cont_if = 1'b0;
  logic [ADDR_W-1:0] we_addr = '0;
  logic [DATA_W-1:0] we_data = '0;

  task automatic applyStimulus(input bit dr, input bit dw, input logic [ADDR_W-1:0] da,
                               input logic [DATA_W-1:0] dwd, input bit ir,
                               input logic [ADDR_W-1:0] ia, input bit expect_done);
    @(posedge clk);
    #1;
    dm_read  = dr;
    dm_write = dw;
    dm_addr  = da;
    dm_wdata = dwd;
    if_req   = ir;
    if_addr  = ia;
    if (expect_done) begin
      if (dr) begin
        dm_hold = mem_word(da);
        dm_exp.push_back(dm_hold);
      end
      if (dw) dm_exp.push_back(dm_hold);
      if (ir) begin
        if_hold = mem_word(ia);
        if_exp.push_back(if_hold);
      end
    end
  endtask

  // Runs n cycles as the requesters: drop (or re-raise) a request after its ready.
  task automatic runCycles(input int n);
    bit drop_d, drop_i;
    mem_en_cnt = 0; we_cnt = 0; we_bad = 0; stall_cnt = 0; pc_bad = 0;
    dm_rdy_cnt = 0; if_rdy_cnt = 0; dm_rdy_at = 0; if_rdy_at = 0;
    last_d = 0; last_i = 0; max_gap = 0; ord_n = 0; ord_bits = '0;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      drop_d = 1'b0;
      drop_i = 1'b0;
      if (mem_en) mem_en_cnt++;
      if (mem_en && mem_we) begin
        we_cnt++;
        if (mem_addr !== we_addr || mem_wdata !== we_data) we_bad++;
      end
      if (pipe_stall) stall_cnt++;
      if (if_req && !if_ready && pc_write) pc_bad++;
      if (if_req && if_ready && !pc_write) pc_bad++;
      if (pc_write !== ifid_write) pc_bad++;
      if (dm_ready) begin
        dm_rdy_cnt++;
        if (dm_rdy_at == 0) dm_rdy_at = k;
        if (last_d != 0 && k - last_d > max_gap) max_gap = k - last_d;
        last_d = k;
        ord_bits = {ord_bits[30:0], 1'b1};
        ord_n++;
        drop_d = 1'b1;
      end
      if (if_ready) begin
        if_rdy_cnt++;
        if (if_rdy_at == 0) if_rdy_at = k;
        if (last_i != 0 && k - last_i > max_gap) max_gap = k - last_i;
        last_i = k;
        ord_bits = {ord_bits[30:0], 1'b0};
        ord_n++;
        drop_i = 1'b1;
      end
      @(posedge clk);
      #1;
      if (drop_d) begin
        if (cont_dm) begin
          dm_addr = dm_addr + 12'd1;
          dm_hold = mem_word(dm_addr);
          dm_exp.push_back(dm_hold);
        end else begin
          dm_read  = 1'b0;
          dm_write = 1'b0;
        end
      end
      if (drop_i) begin
        if (cont_if) begin
          if_addr = if_addr + 12'd1;
          if_hold = mem_word(if_addr);
          if_exp.push_back(if_hold);
        end else begin
          if_req = 1'b0;
        end
      end
    end
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_if_ready"}, {31'd0, if_ready}, 32'd0);
    checkOutput({tag, "_dm_ready"}, {31'd0, dm_ready}, 32'd0);
    checkOutput({tag, "_mem_en"}, {31'd0, mem_en}, 32'd0);
    checkOutput({tag, "_mem_we"}, {31'd0, mem_we}, 32'd0);
    checkOutput({tag, "_mem_addr"}, {20'd0, mem_addr}, 32'd0);
    checkOutput({tag, "_mem_wdata"}, {16'd0, mem_wdata}, 32'd0);
    checkOutput({tag, "_if_rdata"}, {16'd0, if_rdata}, 32'd0);
    checkOutput({tag, "_dm_rdata"}, {16'd0, dm_rdata}, 32'd0);
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    checkResetValues("rst");
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Fetch only
    applyStimulus(1'b0, 1'b0, 12'h000, 16'h0000, 1'b1, 12'h010, 1'b1);
    runCycles(6);
    checkOutput("f_if_ready_cnt", if_rdy_cnt, 1);
    checkOutput("f_if_ready_cycle", if_rdy_at, 4);
    checkOutput("f_mem_en_cycles", mem_en_cnt, LAT);
    checkOutput("f_pc_write", pc_bad, 0);
    checkOutput("f_value", {16'd0, if_rdata}, 32'h0000A5C3);

    // Simultaneous request from idle: data first, fetch immediately after
    applyStimulus(1'b1, 1'b0, 12'h100, 16'h0000, 1'b1, 12'h012, 1'b1);
    runCycles(8);
    checkOutput("s_dm_ready_cycle", dm_rdy_at, 4);
    checkOutput("s_if_ready_cycle", if_rdy_at, 6);
    checkOutput("s_mem_en_cycles", mem_en_cnt, 2 * LAT);
    checkOutput("s_stall_cycles", stall_cnt, 3);
    checkOutput("s_order", ord_bits, 32'b10);
    checkOutput("s_pc_write", pc_bad, 0);

    // Continuous requests from both sides alternate
    cont_dm = 1'b1;
    cont_if = 1'b1;
    applyStimulus(1'b1, 1'b0, 12'h300, 16'h0000, 1'b1, 12'h040, 1'b1);
    runCycles(16);
    checkOutput("a_order_count", ord_n, 7);
    checkOutput("a_order", ord_bits, 32'h55);
    checkOutput("a_max_gap", {31'd0, max_gap <= 2 * LAT}, 32'd1);
    cont_dm = 1'b0;
    cont_if = 1'b0;
    runCycles(8);
    checkOutput("a_drain_dm", dm_rdy_cnt, 1);
    checkOutput("a_drain_if", if_rdy_cnt, 1);
    checkOutput("a_if_queue_empty", if_exp.size(), 0);
    checkOutput("a_dm_queue_empty", dm_exp.size(), 0);

    // Store
    we_addr = 12'h0FF;
    we_data = 16'h1234;
    applyStimulus(1'b0, 1'b1, 12'h0FF, 16'h1234, 1'b0, 12'h000, 1'b1);
    runCycles(6);
    checkOutput("w_we_cycles", we_cnt, LAT);
    checkOutput("w_stable", we_bad, 0);
    checkOutput("w_dm_ready_cnt", dm_rdy_cnt, 1);
    checkOutput("w_dm_ready_cycle", dm_rdy_at, 4);
    checkOutput("w_mem_content", {16'd0, mem_word(12'h0FF)}, 32'h00001234);

    // Flush during the first cycle of a fetch
    applyStimulus(1'b0, 1'b0, 12'h000, 16'h0000, 1'b1, 12'h030, 1'b0);
    @(negedge clk);
    @(posedge clk);
    #1;
    flush   = 1'b1;
    if_addr = 12'h020;
    @(negedge clk);
    checkOutput("fl_busy_mem_en", {31'd0, mem_en}, 32'd1);
    checkOutput("fl_busy_if_ready", {31'd0, if_ready}, 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("fl_abort_mem_en", {31'd0, mem_en}, 32'd0);
    checkOutput("fl_abort_if_ready", {31'd0, if_ready}, 32'd0);
    checkOutput("fl_if_rdata_held", {16'd0, if_rdata}, {16'd0, if_hold});
    @(posedge clk);
    #1;
    flush   = 1'b0;
    if_hold = mem_word(12'h020);
    if_exp.push_back(if_hold);
    runCycles(6);
    checkOutput("fl_regrant_cnt", if_rdy_cnt, 1);
    checkOutput("fl_regrant_cycle", if_rdy_at, 4);

    // Asynchronous reset in the middle of a data access
    applyStimulus(1'b1, 1'b0, 12'h200, 16'h0000, 1'b0, 12'h000, 1'b0);
    @(negedge clk);
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("r_busy_mem_en", {31'd0, mem_en}, 32'd1);
    #2;
    rst = 1'b0;
    #1;
    checkResetValues("r_mid");
    dm_read = 1'b0;
    if_hold = '0;
    dm_hold = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    runCycles(4);
    checkOutput("r_after_mem_en", mem_en_cnt, 0);
    checkOutput("r_after_ready", dm_rdy_cnt + if_rdy_cnt, 0);
    checkOutput("r_dm_queue_empty", dm_exp.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
